// File: rtl/lfsr_stream_cipher_wide.sv
// Dual-direction LFSR XOR stream cipher: TX encrypt and RX decrypt lanes, W bits per beat,
// sharing one serially-loaded configuration {taps, seed, invert, bypass}.

module lfsr_stream_lane #(
    parameter int            M          = 32,
    parameter int            W          = 8,
    parameter logic [M-1:0]  RESET_SEED = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [M-1:0] seed,
    input  logic [M-1:0] taps,
    input  logic         bypass,
    input  logic         invert,
    input  logic         beat,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         dout_valid
);
    logic [M-1:0] s, base, nxt;
    logic [W-1:0] ks, mask;

    // A reload in the same cycle as a beat feeds the fresh seed straight into the step.
    always_comb begin
        base = load ? seed : s;
        nxt  = base;
        ks   = '0;
        for (int i = 0; i < W; i++) begin
            ks[i] = nxt[M-1];
            nxt   = {nxt[M-2:0], ^(nxt & taps)};
        end
    end

    assign mask = bypass ? '0 : (invert ? ~ks : ks);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s          <= RESET_SEED;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= beat;
            if (beat) begin
                s    <= nxt;
                dout <= din ^ mask;
            end else begin
                s    <= base;
            end
        end
    end
endmodule

module lfsr_stream_cipher_wide #(
    parameter int            M            = 32,
    parameter int            W            = 8,
    parameter logic [M-1:0]  DEFAULT_SEED = M'(32'hACE1_0001),
    parameter logic [M-1:0]  DEFAULT_TAPS = M'(32'h8020_0003)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cfg_en,
    input  logic         cfg_i,
    output logic         cfg_o,
    input  logic         resync,
    input  logic         tx_valid,
    output logic         tx_ready,
    input  logic [W-1:0] tx_data,
    output logic         tx_out_valid,
    output logic [W-1:0] tx_out,
    input  logic         rx_valid,
    output logic         rx_ready,
    input  logic [W-1:0] rx_data,
    output logic         rx_out_valid,
    output logic [W-1:0] rx_out,
    output logic [7:0]   beat_cnt
);
    localparam int CW        = 2*M + 2;
    localparam int NUM_LANES = 2;

    logic [CW-1:0] cfg_chain;
    logic          cfg_en_q;
    logic [M-1:0]  taps_cfg, seed_cfg, taps_eff, seed_eff;
    logic          invert, bypass, reload;

    logic [NUM_LANES-1:0]          lane_beat, lane_oval;
    logic [NUM_LANES-1:0][W-1:0]   lane_din, lane_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_chain <= '0;
            cfg_en_q  <= 1'b0;
        end else begin
            cfg_en_q <= cfg_en;
            if (cfg_en)
                cfg_chain <= {cfg_chain[CW-2:0], cfg_i};
        end
    end

    assign cfg_o    = cfg_chain[CW-1];
    assign taps_cfg = cfg_chain[CW-1 -: M];
    assign seed_cfg = cfg_chain[M+1:2];
    assign invert   = cfg_chain[1];
    assign bypass   = cfg_chain[0];
    assign taps_eff = (taps_cfg == '0) ? DEFAULT_TAPS : taps_cfg;
    assign seed_eff = (seed_cfg == '0) ? DEFAULT_SEED : seed_cfg;

    // Config shifting freezes everything; its trailing edge and resync both reseed.
    assign reload   = ~cfg_en & (cfg_en_q | resync);
    assign tx_ready = ~cfg_en;
    assign rx_ready = ~cfg_en;

    assign lane_beat = {rx_valid & ~cfg_en, tx_valid & ~cfg_en};
    assign lane_din  = {rx_data, tx_data};

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        lfsr_stream_lane #(.M(M), .W(W), .RESET_SEED(DEFAULT_SEED)) u_lane (
            .clk        (clk),
            .rst        (rst),
            .load       (reload),
            .seed       (seed_eff),
            .taps       (taps_eff),
            .bypass     (bypass),
            .invert     (invert),
            .beat       (lane_beat[g]),
            .din        (lane_din[g]),
            .dout       (lane_dout[g]),
            .dout_valid (lane_oval[g])
        );
    end

    assign tx_out       = lane_dout[0];
    assign tx_out_valid = lane_oval[0];
    assign rx_out       = lane_dout[1];
    assign rx_out_valid = lane_oval[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            beat_cnt <= 8'd0;
        else if (lane_beat[0])
            beat_cnt <= beat_cnt + 8'd1;
    end
endmodule

// File: tb/tb_lfsr_stream_cipher_wide.sv
// Self-checking bench: constant vectors on a 4-bit LFSR instance, randomized traffic on the
// default 32-bit instance checked against a linear-recurrence keystream model.

module tb_lfsr_stream_cipher_wide;
    localparam int M  = 32;
    localparam int W  = 8;
    localparam int CW = 2*M + 2;
    localparam logic [31:0] DT = 32'h8020_0003;
    localparam logic [31:0] DS = 32'hACE1_0001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         cfg_en, cfg_i, cfg_o, resync;
    logic         tx_valid, tx_ready, tx_out_valid, rx_valid, rx_ready, rx_out_valid;
    logic [W-1:0] tx_data, tx_out, rx_data, rx_out;
    logic [7:0]   beat_cnt;

    logic         s_cfg_en, s_cfg_i, s_cfg_o, s_resync;
    logic         s_tx_valid, s_tx_ready, s_tx_out_valid, s_rx_valid, s_rx_ready, s_rx_out_valid;
    logic [7:0]   s_tx_data, s_tx_out, s_rx_data, s_rx_out, s_beat_cnt;

    lfsr_stream_cipher_wide #(.M(M), .W(W)) dut (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_i(cfg_i), .cfg_o(cfg_o), .resync(resync),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_out_valid(tx_out_valid), .tx_out(tx_out),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .rx_out_valid(rx_out_valid), .rx_out(rx_out), .beat_cnt(beat_cnt)
    );

    lfsr_stream_cipher_wide #(.M(4), .W(8), .DEFAULT_SEED(4'h1), .DEFAULT_TAPS(4'h9)) dut4 (
        .clk(clk), .rst(rst), .cfg_en(s_cfg_en), .cfg_i(s_cfg_i), .cfg_o(s_cfg_o), .resync(s_resync),
        .tx_valid(s_tx_valid), .tx_ready(s_tx_ready), .tx_data(s_tx_data),
        .tx_out_valid(s_tx_out_valid), .tx_out(s_tx_out),
        .rx_valid(s_rx_valid), .rx_ready(s_rx_ready), .rx_data(s_rx_data),
        .rx_out_valid(s_rx_out_valid), .rx_out(s_rx_out), .beat_cnt(s_beat_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: keystream is the sequence a[n+M] = XOR_j taps[j] & a[n+M-1-j], key bit = a[n].
    logic [65:0] m_chain;
    bit          mw [2][32];
    logic [7:0]  m_last [2];
    logic [7:0]  m_cnt;

    function automatic logic [31:0] f_taps();
        return (m_chain[65:34] == 32'd0) ? DT : m_chain[65:34];
    endfunction

    function automatic logic [31:0] f_seed();
        return (m_chain[33:2] == 32'd0) ? DS : m_chain[33:2];
    endfunction

    function automatic logic [7:0] f_mask(input logic [7:0] k);
        if (m_chain[0]) return 8'h00;
        return m_chain[1] ? ~k : k;
    endfunction

    task automatic m_load();
        logic [31:0] sd;
        sd = f_seed();
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 32; i++) mw[l][i] = sd[31-i];
    endtask

    task automatic m_step(input int l, output logic [7:0] k);
        logic [31:0] t;
        bit nb;
        t = f_taps();
        for (int i = 0; i < 8; i++) begin
            k[i] = mw[l][0];
            nb = 1'b0;
            for (int j = 0; j < 32; j++) nb ^= t[j] & mw[l][31-j];
            for (int j = 0; j < 31; j++) mw[l][j] = mw[l][j+1];
            mw[l][31] = nb;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        chk("rst_tx_out", 66'(tx_out), 66'h0);
        chk("rst_tx_vld", 66'(tx_out_valid), 66'h0);
        chk("rst_rx_out", 66'(rx_out), 66'h0);
        chk("rst_rx_vld", 66'(rx_out_valid), 66'h0);
        chk("rst_beat_cnt", 66'(beat_cnt), 66'h0);
        chk("rst_cfg_o", 66'(cfg_o), 66'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_chain = '0;
        m_load();
        m_last[0] = 8'h00;
        m_last[1] = 8'h00;
        m_cnt = 8'h00;
    endtask

    task automatic shift(input logic [65:0] p, input bit rb, input logic [65:0] rbp);
        for (int i = CW-1; i >= 0; i--) begin
            cfg_en = 1'b1;
            cfg_i  = p[i];
            #1;
            if (rb) begin
                chk("cfg_o_readback", 66'(cfg_o), 66'(rbp[i]));
                chk("ready_during_cfg", 66'({tx_ready, rx_ready}), 66'h0);
            end
            @(posedge clk); #1;
            m_chain = {m_chain[64:0], p[i]};
        end
        cfg_en = 1'b0;
        cfg_i  = 1'b0;
    endtask

    task automatic cfg_load(input logic [65:0] p);
        shift(p, 1'b0, '0);
        @(posedge clk); #1;
        m_load();
    endtask

    task automatic cycle(input bit tv, input logic [7:0] td, input bit rv, input logic [7:0] rd, input bit rs);
        logic [7:0] k;
        tx_valid = tv; tx_data = td; rx_valid = rv; rx_data = rd; resync = rs;
        if (rs) m_load();
        if (tv) begin m_step(0, k); m_last[0] = td ^ f_mask(k); m_cnt++; end
        if (rv) begin m_step(1, k); m_last[1] = rd ^ f_mask(k); end
        @(posedge clk); #1;
        tx_valid = 1'b0; rx_valid = 1'b0; resync = 1'b0;
        chk("tx_out_valid", 66'(tx_out_valid), 66'(tv));
        chk("tx_out", 66'(tx_out), 66'(m_last[0]));
        chk("rx_out_valid", 66'(rx_out_valid), 66'(rv));
        chk("rx_out", 66'(rx_out), 66'(m_last[1]));
        chk("beat_cnt", 66'(beat_cnt), 66'(m_cnt));
    endtask

    typedef struct {
        logic [3:0] taps;
        logic [3:0] seed;
        logic       inv;
        logic       byp;
        logic [7:0] din;
        logic [7:0] dout;
    } v4_t;

    v4_t tab [6];

    task automatic run4(input v4_t v);
        logic [9:0] p;
        p = {v.taps, v.seed, v.inv, v.byp};
        for (int i = 9; i >= 0; i--) begin
            s_cfg_en = 1'b1; s_cfg_i = p[i];
            @(posedge clk); #1;
        end
        chk("s_cfg_o", 66'(s_cfg_o), 66'(v.taps[3]));
        s_cfg_en = 1'b0; s_cfg_i = 1'b0;
        @(posedge clk); #1;
        s_tx_valid = 1'b1; s_tx_data = v.din; s_rx_valid = 1'b1; s_rx_data = v.din;
        #1;
        chk("s_ready", 66'({s_tx_ready, s_rx_ready}), 66'h3);
        @(posedge clk); #1;
        s_tx_valid = 1'b0; s_rx_valid = 1'b0;
        chk("s_tx_out", 66'(s_tx_out), 66'(v.dout));
        chk("s_rx_out", 66'(s_rx_out), 66'(v.dout));
        chk("s_valids", 66'({s_tx_out_valid, s_rx_out_valid}), 66'h3);
    endtask

    initial begin
        logic [7:0]  ct [16];
        logic [7:0]  dd [6];
        logic [7:0]  ref_o [6];
        logic [65:0] p;
        logic [7:0]  first;
        logic [7:0]  exp_cnt4;

        tab[0] = '{4'h9, 4'h1, 1'b0, 1'b0, 8'h00, 8'h78};
        tab[1] = '{4'h9, 4'h1, 1'b1, 1'b0, 8'h00, 8'h87};
        tab[2] = '{4'h9, 4'h1, 1'b0, 1'b1, 8'hA5, 8'hA5};
        tab[3] = '{4'h9, 4'h1, 1'b0, 1'b0, 8'hFF, 8'h87};
        tab[4] = '{4'h9, 4'h1, 1'b1, 1'b0, 8'h5A, 8'hDD};
        tab[5] = '{4'h0, 4'h0, 1'b0, 1'b0, 8'h00, 8'h78};

        cfg_en = 0; cfg_i = 0; resync = 0; tx_valid = 0; rx_valid = 0; tx_data = 0; rx_data = 0;
        s_cfg_en = 0; s_cfg_i = 0; s_resync = 0; s_tx_valid = 0; s_rx_valid = 0;
        s_tx_data = 0; s_rx_data = 0;
        m_chain = '0;
        do_reset();

        exp_cnt4 = 8'd0;
        for (int i = 0; i < 6; i++) begin
            run4(tab[i]);
            exp_cnt4++;
            chk("s_beat_cnt", 66'(s_beat_cnt), 66'(exp_cnt4));
        end

        // Right after reset the zero chain selects the defaults.
        cycle(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0);

        // Round trip with default config.
        cfg_load('0);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 8'hF0, 1'b0, 8'h00, 1'b0);
            ct[i] = tx_out;
        end
        do_reset();
        cfg_load('0);
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, 8'h00, 1'b1, ct[i], 1'b0);
            chk("roundtrip_plain", 66'(rx_out), 66'hF0);
        end

        // Zero config vs explicit default config.
        cfg_load('0);
        for (int i = 0; i < 6; i++) begin
            dd[i] = 8'($urandom);
            cycle(1'b1, dd[i], 1'b0, 8'h00, 1'b0);
            ref_o[i] = tx_out;
        end
        cfg_load({DT, DS, 2'b00});
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, dd[i], 1'b0, 8'h00, 1'b0);
            chk("default_fallback", 66'(tx_out), 66'(ref_o[i]));
        end

        // Readback of the chain.
        p = {$urandom, $urandom, 2'($urandom)};
        shift(p, 1'b0, '0);
        shift('0, 1'b1, p);
        @(posedge clk); #1;
        m_load();

        // Resync with the 4th beat replays the 1st beat's key.
        cfg_load({$urandom | 32'h1, $urandom | 32'h1, 2'b00});
        cycle(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        first = tx_out;
        cycle(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 8'h00, 1'b0, 8'h00, 1'b1);
        chk("resync_replay", 66'(tx_out), 66'(first));
        cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        // Randomized configs and traffic, including zero fields, bypass, invert, resync.
        for (int c = 0; c < 4; c++) begin
            p[65:34] = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            p[33:2]  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
            p[1:0]   = 2'($urandom);
            cfg_load(p);
            for (int i = 0; i < 60; i++)
                cycle(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                      $urandom_range(0, 9) == 0);
        end

        // Enough TX beats to wrap beat_cnt.
        for (int i = 0; i < 260; i++)
            cycle(1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0);

        // Asynchronous reset mid-stream, configuration dropped back to defaults.
        cfg_load({32'h0000_00C1, 32'h1234_5678, 2'b10});
        cycle(1'b1, 8'h55, 1'b1, 8'hAA, 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 8'($urandom), 1'b1, 8'($urandom), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
